// File: rtl/boton_sube_nivel.sv
// Player raise button: sync, debounce, gate by habilitado/Nivel, emit one active-low raise pulse.
// Pulse is low in the cycle after edge DEBOUNCE_CYCLES+2 from the first low sample; AUTO_REPEAT_EN adds hold-to-repeat.
module boton_sube_nivel #(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned REPEAT_CYCLES   = 65,
    parameter int unsigned NIVEL_MAX       = 3
) (
    input  logic       clk,
    input  logic       B_reset,
    input  logic       boton_n,
    input  logic       habilitado,
    input  logic [1:0] Nivel,
    output logic       Sube_Nivel_n,
    output logic       Rechazo,
    output logic       Presionado,
    output logic [7:0] Contador_Pulsos
);

    localparam int unsigned DEB_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 2 || REPEAT_CYCLES < 2) begin : g_param_check
        $error("boton_sube_nivel: DEBOUNCE_CYCLES and REPEAT_CYCLES must be >= 2");
    end

    typedef enum logic [1:0] {
        REPOSO,
        FILTRO_PRESION,
        PRESIONADO,
        FILTRO_LIBERA
    } estado_t;

    estado_t          estado_q, estado_d;
    logic             sync1_q, sync2_q;
    logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;
    logic             sube_n_q, sube_n_d;
    logic             rechazo_q, rechazo_d;
    logic [7:0]       cuenta_q, cuenta_d;
    logic             btn_s;
    logic             decide;
    logic             permitido;

`ifdef AUTO_REPEAT_EN
    localparam int unsigned REP_W = $clog2(REPEAT_CYCLES);
    localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES - 1);
    logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
`endif

    assign btn_s = sync2_q;

    always_comb begin
        estado_d  = estado_q;
        deb_cnt_d = deb_cnt_q;
        decide    = 1'b0;
`ifdef AUTO_REPEAT_EN
        rep_cnt_d = '0;
`endif
        case (estado_q)
            REPOSO: begin
                if (!btn_s) begin
                    estado_d  = FILTRO_PRESION;
                    deb_cnt_d = '0;
                end
            end
            FILTRO_PRESION: begin
                if (btn_s) begin
                    estado_d = REPOSO;
                end else if (deb_cnt_q == DEB_LAST) begin
                    estado_d = PRESIONADO;
                    decide   = 1'b1;
                end else begin
                    deb_cnt_d = deb_cnt_q + 1'b1;
                end
            end
            PRESIONADO: begin
                if (btn_s) begin
                    estado_d  = FILTRO_LIBERA;
                    deb_cnt_d = '0;
                end
`ifdef AUTO_REPEAT_EN
                // Repeat period restarts whenever the hold is interrupted.
                else if (rep_cnt_q == REP_LAST) begin
                    decide = 1'b1;
                end else begin
                    rep_cnt_d = rep_cnt_q + 1'b1;
                end
`endif
            end
            FILTRO_LIBERA: begin
                if (!btn_s) begin
                    estado_d = PRESIONADO;
                end else if (deb_cnt_q == DEB_LAST) begin
                    estado_d = REPOSO;
                end else begin
                    deb_cnt_d = deb_cnt_q + 1'b1;
                end
            end
            default: estado_d = REPOSO;
        endcase

        permitido = habilitado && (32'(Nivel) < NIVEL_MAX);
        sube_n_d  = !(decide && permitido);
        rechazo_d = decide && !permitido;
        cuenta_d  = (decide && permitido) ? cuenta_q + 8'd1 : cuenta_q;
    end

    always_ff @(posedge clk or negedge B_reset) begin
        if (!B_reset) begin
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            estado_q  <= REPOSO;
            deb_cnt_q <= '0;
            sube_n_q  <= 1'b1;
            rechazo_q <= 1'b0;
            cuenta_q  <= 8'd0;
        end else begin
            sync1_q   <= boton_n;
            sync2_q   <= sync1_q;
            estado_q  <= estado_d;
            deb_cnt_q <= deb_cnt_d;
            sube_n_q  <= sube_n_d;
            rechazo_q <= rechazo_d;
            cuenta_q  <= cuenta_d;
        end
    end

`ifdef AUTO_REPEAT_EN
    always_ff @(posedge clk or negedge B_reset) begin
        if (!B_reset) begin
            rep_cnt_q <= '0;
        end else begin
            rep_cnt_q <= rep_cnt_d;
        end
    end
`endif

    assign Sube_Nivel_n    = sube_n_q;
    assign Rechazo         = rechazo_q;
    assign Presionado      = (estado_q == PRESIONADO) || (estado_q == FILTRO_LIBERA);
    assign Contador_Pulsos = cuenta_q;

endmodule

// File: tb/tb_boton_sube_nivel.sv
// Bench for boton_sube_nivel: directed and randomized button waveforms, run-length reference model, pulse scoreboard.
module tb_boton_sube_nivel;

    localparam int DEB  = 16;
    localparam int REP  = 65;
    localparam int NMAX = 3;

    logic       clk = 1'b0;
    logic       B_reset = 1'b0;
    logic       boton_n = 1'b1;
    logic       habilitado = 1'b0;
    logic [1:0] Nivel = 2'd0;
    logic       Sube_Nivel_n;
    logic       Rechazo;
    logic       Presionado;
    logic [7:0] Contador_Pulsos;

    boton_sube_nivel #(
        .DEBOUNCE_CYCLES(DEB),
        .REPEAT_CYCLES  (REP),
        .NIVEL_MAX      (NMAX)
    ) dut (
        .clk            (clk),
        .B_reset        (B_reset),
        .boton_n        (boton_n),
        .habilitado     (habilitado),
        .Nivel          (Nivel),
        .Sube_Nivel_n   (Sube_Nivel_n),
        .Rechazo        (Rechazo),
        .Presionado     (Presionado),
        .Contador_Pulsos(Contador_Pulsos)
    );

    initial forever #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        int   cyc;
        logic pulse;
    } exp_t;
    exp_t q[$];

    // Reference model: samples seen two edges late; debounced state flips after DEB+1 consecutive differing samples.
    logic pipe0 = 1'b1, pipe1 = 1'b1;
    logic held = 1'b0;
    int   run = 0;
    int   since = 0;
    int   m_count = 0;

    initial begin
        logic bs, want, differ, decide, ok;
`ifdef AUTO_REPEAT_EN
        logic held_prev;
        int   run_prev;
`endif
        forever begin
            @(posedge clk);
            cyc++;
            if (!B_reset) begin
                pipe0 = 1'b1; pipe1 = 1'b1; held = 1'b0;
                run = 0; since = 0; m_count = 0;
                q.delete();
            end else begin
                bs = pipe1; pipe1 = pipe0; pipe0 = boton_n;
                want   = !bs;
                differ = (want != held);
                decide = 1'b0;
`ifdef AUTO_REPEAT_EN
                held_prev = held;
                run_prev  = run;
`endif
                if (differ) run++; else run = 0;
                if (run == DEB + 1) begin
                    held   = want;
                    run    = 0;
                    decide = held;
                end
`ifdef AUTO_REPEAT_EN
                if (held_prev && held && run_prev == 0 && !differ) begin
                    since++;
                    if (since == REP) begin
                        since  = 0;
                        decide = 1'b1;
                    end
                end else begin
                    since = 0;
                end
`endif
                if (decide) begin
                    ok = habilitado && (int'(Nivel) < NMAX);
                    if (ok) m_count = (m_count + 1) % 256;
                    q.push_back('{cyc, ok});
                end
            end
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!B_reset) begin
                check("rst_sube", 32'(Sube_Nivel_n), 32'd1);
                check("rst_rechazo", 32'(Rechazo), 32'd0);
                check("rst_presionado", 32'(Presionado), 32'd0);
                check("rst_contador", 32'(Contador_Pulsos), 32'd0);
                q.delete();
            end else begin
                check("presionado", 32'(Presionado), 32'(held));
                check("contador", 32'(Contador_Pulsos), 32'(m_count[7:0]));
                while (q.size() > 0 && q[0].cyc < cyc) begin
                    e = q.pop_front();
                    total++;
                    bad++;
                    $display("FAIL missed_decision: got none expected pulse=%0b for cycle %0d", e.pulse, e.cyc);
                end
                if (q.size() > 0 && q[0].cyc == cyc) begin
                    e = q.pop_front();
                    check("sube_pulse", 32'(Sube_Nivel_n), 32'(!e.pulse));
                    check("rechazo_pulse", 32'(Rechazo), 32'(!e.pulse));
                end else begin
                    check("idle_sube", 32'(Sube_Nivel_n), 32'd1);
                    check("idle_rechazo", 32'(Rechazo), 32'd0);
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic press(input int hold_cyc, input int rel_cyc);
        boton_n = 1'b0;
        step(hold_cyc);
        boton_n = 1'b1;
        step(rel_cyc);
    endtask

    initial begin
        habilitado = 1'b1;
        Nivel      = 2'd1;
        step(3);
        B_reset = 1'b1;
        step(5);

        // Clean press, then levels just below and at saturation, then disabled.
        press(40, 30);
        Nivel = 2'd2; press(40, 30);
        Nivel = 2'd3; press(40, 30);
        Nivel = 2'd0; habilitado = 1'b0; press(40, 30);
        habilitado = 1'b1;

        // Bounce shorter than the debounce window.
        for (int i = 0; i < 6; i++) begin
            boton_n = ~boton_n;
            step(5);
        end
        boton_n = 1'b1;
        step(30);

        // Release with bounces back to low.
        boton_n = 1'b0; step(40);
        for (int i = 0; i < 3; i++) begin
            boton_n = 1'b1; step(6);
            boton_n = 1'b0; step(4);
        end
        boton_n = 1'b1; step(40);

        // Reset during a press, button kept held through release.
        boton_n = 1'b0; step(10);
        B_reset = 1'b0; step(2);
        B_reset = 1'b1; step(40);
        boton_n = 1'b1; step(30);

        // Long hold: single pulse, or periodic pulses with auto-repeat.
        press(200, 30);

        // Random presses with habilitado/Nivel changing every cycle.
        for (int i = 0; i < 60; i++) begin
            int len;
            len = $urandom_range(1, 45);
            boton_n = ~boton_n;
            for (int j = 0; j < len; j++) begin
                habilitado = 1'($urandom_range(0, 1));
                Nivel      = 2'($urandom_range(0, 3));
                step(1);
            end
        end
        boton_n = 1'b1;
        step(30);

        // Enough accepted presses to wrap the pulse counter.
        habilitado = 1'b1;
        Nivel      = 2'd0;
        for (int i = 0; i < 260; i++) press(20, 20);

        step(60);
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL queue_drain: got %0d pending expected 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/boton_sube_nivel.md
Name: boton_sube_nivel

Overview:
- Conditions the raw player pushbutton that raises a pet stat level and drives the level counter's active-low "raise" input.
- The level counter raises the level on every cycle its raise input is low, so this block must deliver exactly one clean one-cycle active-low pulse per physical press.
- Stages: synchronizer, debounce FSM, saturation gating using the counter's current Nivel, optional hold-to-repeat.
- Sits between the board button pin and the level counter, one instance per stat.

Parameters:
DEBOUNCE_CYCLES, 16, cycles the synchronized button must be stable before a press or release is accepted (legal range >= 2)
REPEAT_CYCLES, 65, cycles between auto-repeat pulses while held (used only with the optional feature)
NIVEL_MAX, 3, level value at which raise pulses are suppressed

Ports:
clk  input  1  system clock
B_reset  input  1  reset, asynchronous, active-low
boton_n  input  1  raw pushbutton, active-low, asynchronous to clk
habilitado  input  1  1 = pet active and raise pulses allowed
Nivel  input  2  current level fed back from the level counter
Sube_Nivel_n  output  1  one-cycle active-low raise pulse, registered
Rechazo  output  1  one-cycle high pulse when an accepted press is blocked, registered
Presionado  output  1  debounced button state, 1 = held
Contador_Pulsos  output  8  count of raise pulses issued, wraps 255 -> 0

Behaviour:
- Reset values (asynchronous, B_reset low):
  - Sube_Nivel_n=1, Rechazo=0, Presionado=0, Contador_Pulsos=0.
  - Both synchronizer flops=1, FSM=REPOSO, all counters=0.
- Synchronizer: two flops on boton_n produce btn_s. This adds 2 cycles of latency.
- Debounce counter width is clog2(DEBOUNCE_CYCLES).
- FSM states and transitions:
  - REPOSO: if btn_s=0, go to FILTRO_PRESION and clear the counter.
  - FILTRO_PRESION:
    - If btn_s=1, go back to REPOSO. No pulse.
    - Else if counter==DEBOUNCE_CYCLES-1, go to PRESIONADO and run the pulse decision.
    - Else increment the counter.
  - PRESIONADO: if btn_s=1, go to FILTRO_LIBERA and clear the counter.
  - FILTRO_LIBERA:
    - If btn_s=0, go back to PRESIONADO. No new pulse, and the repeat counter is cleared.
    - Else if counter==DEBOUNCE_CYCLES-1, go to REPOSO.
    - Else increment the counter.
- Presionado=1 in PRESIONADO and in FILTRO_LIBERA; 0 otherwise.
- Pulse decision uses habilitado and Nivel sampled on the same edge:
  - If habilitado=1 and Nivel<NIVEL_MAX: Sube_Nivel_n=0 for exactly one cycle and Contador_Pulsos increments.
  - Otherwise: Rechazo=1 for exactly one cycle, Sube_Nivel_n stays 1, and the count is unchanged.
- Latency: take edge 0 as the first edge sampling boton_n low, with the button stable afterwards. Sube_Nivel_n is low in the cycle after edge DEBOUNCE_CYCLES+2 (edge 18 for the default).
- A glitch shorter than DEBOUNCE_CYCLES synchronized cycles produces no pulse and no Rechazo.
- A bounce during release (return to PRESIONADO) never produces a second pulse.
- Sube_Nivel_n and Rechazo are never asserted in the same cycle.
- Reset asserted mid-debounce or mid-pulse immediately forces the reset values. After release, a button still held must pass the full debounce before any pulse.
- habilitado and Nivel are ignored outside the pulse-decision edge.

Optional Feature:
- Macro: AUTO_REPEAT_EN.
- Defined:
  - In PRESIONADO a repeat counter (width clog2(REPEAT_CYCLES)) increments each cycle.
  - When it reaches REPEAT_CYCLES-1, it clears and a new pulse decision is made (same gating and Rechazo rules).
  - The repeat counter is cleared on entering PRESIONADO and in every other state.
  - Holding the button yields the first pulse, then one pulse every REPEAT_CYCLES cycles.
- Undefined: no repeat counter. Exactly one pulse decision per debounced press, however long the button is held.

Test Plan:
- Clean press: boton_n low 40 cycles with Nivel=1, habilitado=1 -> one Sube_Nivel_n low pulse in the cycle after edge 18, Contador_Pulsos=1, Presionado=1 until 18 cycles after release.
- Bounce: boton_n toggles every 5 cycles for 30 cycles, then stays high -> no Sube_Nivel_n, no Rechazo, Presionado stays 0.
- Saturation: Nivel=3, clean press -> Rechazo high 1 cycle, Sube_Nivel_n stays 1, Contador_Pulsos unchanged. Repeat with habilitado=0 -> same result.
- Release bounce: hold 40 cycles, release with 3 low glitches of 4 cycles each -> exactly one pulse in total, Presionado falls only after 16 stable-high synchronized cycles.
- Reset mid-op: B_reset low at edge 10 of a press, released at edge 12, button held -> all outputs at reset values, pulse in the cycle after edge 12+18.
- AUTO_REPEAT_EN defined, hold 200 cycles -> pulses at edges 18, 83, 148, 213 relative to the press (the 213 pulse only if still held). Undefined -> a single pulse.
